// File: rtl/vadd_host_driver_pkg.sv
// Opcodes, register ids, FSM states and command record for the vadd host driver.
package vadd_host_pkg;

  localparam logic [31:0] OP_NOP    = 32'd0;
  localparam logic [31:0] OP_WR_REG = 32'd1;
  localparam logic [31:0] OP_RD_REG = 32'd2;
  localparam logic [31:0] OP_WR_MEM = 32'd3;
  localparam logic [31:0] OP_RD_MEM = 32'd4;

  localparam logic [31:0] REG_AP_START = 32'd0;
  localparam logic [31:0] REG_AP_DONE  = 32'd1;
  localparam logic [31:0] REG_A        = 32'd2;
  localparam logic [31:0] REG_B        = 32'd3;
  localparam logic [31:0] REG_C        = 32'd4;
  localparam logic [31:0] REG_LENGTH   = 32'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ALO, S_WR_AHI, S_WR_BLO, S_WR_BHI, S_WR_CLO, S_WR_CHI,
    S_WR_LEN, S_WR_START, S_POLL, S_GAP, S_CLR_DONE, S_READ, S_HOLD, S_FIN
  } state_t;

  typedef struct packed {
    logic [31:0] opcode;
    logic [31:0] id;
    logic [31:0] mask;
    logic [31:0] in;
    logic [31:0] addr;
  } cmd_t;

  function automatic cmd_t wrReg(logic [31:0] regId, logic [31:0] regMask, logic [31:0] data);
    cmd_t c;
    c = '0;
    c.opcode = OP_WR_REG;
    c.id     = regId;
    c.mask   = regMask;
    c.in     = data;
    return c;
  endfunction

endpackage

// File: rtl/vadd_host_driver_if.sv
// Command bus toward the harness responder plus the valid/ready result port.
interface vadd_host_driver_if;

  logic [31:0] opcode;
  logic [31:0] id;
  logic [31:0] mask;
  logic [31:0] in;
  logic [31:0] addr;
  logic [31:0] rsp;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;

  modport master (
    output opcode, id, mask, in, addr,
    input  rsp,
    output rd_valid, rd_data,
    input  rd_ready
  );

  modport slave (
    input  opcode, id, mask, in, addr,
    output rsp,
    input  rd_valid, rd_data,
    output rd_ready
  );

endinterface

// File: rtl/vadd_host_driver.sv
// Host-side command initiator: programs the vadd kernel, polls ap_done, clears it,
// then streams the result vector out of device memory one word at a time.
module vadd_host_driver
  import vadd_host_pkg::*;
#(
  parameter int unsigned POLL_GAP     = 4,
  parameter int unsigned POLL_TIMEOUT = 4096,
  parameter int unsigned ADDR_SHIFT   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [63:0]         a_base,
  input  logic [63:0]         b_base,
  input  logic [63:0]         c_base,
  input  logic [31:0]         length,
  output logic                busy,
  output logic                done,
  output logic                error,
  vadd_host_driver_if.master  bus
);

  localparam logic [31:0] TIMEOUT_W = 32'(POLL_TIMEOUT);
  localparam logic [31:0] GAP_LAST  = 32'(POLL_GAP - 1);

  state_t      state_q, state_d;
  logic [63:0] aBase_q, aBase_d, bBase_q, bBase_d, cBase_q, cBase_d;
  logic [31:0] length_q, length_d;
  logic [31:0] gapCnt_q, gapCnt_d;
  logic [31:0] pollCnt_q, pollCnt_d;
  logic [31:0] idx_q, idx_d;
  cmd_t        cmd_q, cmd_d;
  logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic        rdValid_q, rdValid_d;
  logic [31:0] rdData_q, rdData_d;

  always_comb begin
    state_d   = state_q;
    aBase_d   = aBase_q;
    bBase_d   = bBase_q;
    cBase_d   = cBase_q;
    length_d  = length_q;
    gapCnt_d  = gapCnt_q;
    pollCnt_d = pollCnt_q;
    idx_d     = idx_q;
    error_d   = error_q;
    rdValid_d = rdValid_q;
    rdData_d  = rdData_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_WR_ALO;
          aBase_d   = a_base;
          bBase_d   = b_base;
          cBase_d   = c_base;
          length_d  = length;
          error_d   = 1'b0;
          pollCnt_d = '0;
          gapCnt_d  = '0;
          idx_d     = '0;
        end
      end
      S_WR_ALO:   state_d = S_WR_AHI;
      S_WR_AHI:   state_d = S_WR_BLO;
      S_WR_BLO:   state_d = S_WR_BHI;
      S_WR_BHI:   state_d = S_WR_CLO;
      S_WR_CLO:   state_d = S_WR_CHI;
      S_WR_CHI:   state_d = S_WR_LEN;
      S_WR_LEN:   state_d = S_WR_START;
      S_WR_START: state_d = S_POLL;
      S_POLL: begin
        // A done seen on the final allowed poll still wins over the timeout.
        pollCnt_d = pollCnt_q + 32'd1;
        if (bus.rsp[0]) begin
          state_d = S_CLR_DONE;
        end else if (pollCnt_d >= TIMEOUT_W) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (POLL_GAP == 0) begin
          state_d = S_POLL;
        end else begin
          gapCnt_d = '0;
          state_d  = S_GAP;
        end
      end
      S_GAP: begin
        if (gapCnt_q == GAP_LAST) state_d = S_POLL;
        else                      gapCnt_d = gapCnt_q + 32'd1;
      end
      S_CLR_DONE: begin
        idx_d   = '0;
        state_d = (length_q == 32'd0) ? S_FIN : S_READ;
      end
      S_READ: begin
        rdData_d  = bus.rsp;
        rdValid_d = 1'b1;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        if (rdValid_q && bus.rd_ready) begin
          rdValid_d = 1'b0;
          idx_d     = idx_q + 32'd1;
          state_d   = (idx_d == length_q) ? S_FIN : S_READ;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered in that state's cycle.
    cmd_d = '0;
    unique case (state_d)
      S_WR_ALO:   cmd_d = wrReg(REG_A, 32'd0, aBase_d[31:0]);
      S_WR_AHI:   cmd_d = wrReg(REG_A, 32'd1, aBase_d[63:32]);
      S_WR_BLO:   cmd_d = wrReg(REG_B, 32'd0, bBase_d[31:0]);
      S_WR_BHI:   cmd_d = wrReg(REG_B, 32'd1, bBase_d[63:32]);
      S_WR_CLO:   cmd_d = wrReg(REG_C, 32'd0, cBase_d[31:0]);
      S_WR_CHI:   cmd_d = wrReg(REG_C, 32'd1, cBase_d[63:32]);
      S_WR_LEN:   cmd_d = wrReg(REG_LENGTH, 32'd0, length_d);
      S_WR_START: cmd_d = wrReg(REG_AP_START, 32'd0, 32'd1);
      S_POLL: begin
        cmd_d.opcode = OP_RD_REG;
        cmd_d.id     = REG_AP_DONE;
      end
      S_CLR_DONE: cmd_d = wrReg(REG_AP_DONE, 32'd0, 32'd0);
      S_READ: begin
        cmd_d.opcode = OP_RD_MEM;
        cmd_d.addr   = (cBase_d[31:0] >> ADDR_SHIFT) + idx_d;
      end
      default: cmd_d = '0;
    endcase

    busy_d = !(state_d inside {S_IDLE, S_FIN});
    done_d = (state_d == S_FIN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aBase_q   <= '0;
      bBase_q   <= '0;
      cBase_q   <= '0;
      length_q  <= '0;
      gapCnt_q  <= '0;
      pollCnt_q <= '0;
      idx_q     <= '0;
      cmd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rdValid_q <= 1'b0;
      rdData_q  <= '0;
    end else begin
      state_q   <= state_d;
      aBase_q   <= aBase_d;
      bBase_q   <= bBase_d;
      cBase_q   <= cBase_d;
      length_q  <= length_d;
      gapCnt_q  <= gapCnt_d;
      pollCnt_q <= pollCnt_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      rdValid_q <= rdValid_d;
      rdData_q  <= rdData_d;
    end
  end

  assign bus.opcode   = cmd_q.opcode;
  assign bus.id       = cmd_q.id;
  assign bus.mask     = cmd_q.mask;
  assign bus.in       = cmd_q.in;
  assign bus.addr     = cmd_q.addr;
  assign bus.rd_valid = rdValid_q;
  assign bus.rd_data  = rdData_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: doc/vadd_host_driver.md
# vadd_host_driver

- Cycle-level command initiator for the vadd simulation harness.
- Issues the opcode/id/mask/in/addr command stream that the harness responder executes against the kernel control registers and device memory, and samples the responder's `out` word.
- Sequence per run: program kernel arguments, start the kernel, poll for completion, clear done, then stream the result vector back out through a valid/ready port.

## Interface

Parameters:
- POLL_GAP, 4: NOP cycles between consecutive ap_done polls.
- POLL_TIMEOUT, 4096: maximum polls before aborting with error.
- ADDR_SHIFT, 2: right shift applied to c_base to form the memory word index.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request; accepted only when busy=0.
- a_base, b_base, c_base  in  64 each  kernel buffer arguments; sampled on accepted start.
- length  in  32  element count; sampled on accepted start.
- opcode  out  32  0 NOP, 1 WR_REG, 2 RD_REG, 3 WR_MEM, 4 RD_MEM.
- id  out  32  register id or memory id.
- mask  out  32  32-bit word index within a register.
- in  out  32  write data.
- addr  out  32  memory word address.
- rsp  in  32  responder `out`; combinational response to the current command.
- busy  out  1  high from accepted start until the done pulse.
- done  out  1  one-cycle pulse at run end.
- error  out  1  sticky timeout flag; cleared on next accepted start.
- rd_valid  out  1  result word available.
- rd_ready  in  1  consumer accepts.
- rd_data  out  32  result word.

## Operation

Register ids: 0 ap_start, 1 ap_done, 2 a, 3 b, 4 c, 5 length_r. 64-bit registers use mask 0 for the low word and mask 1 for the high word.

States:
- IDLE
- WR_ALO, WR_AHI, WR_BLO, WR_BHI, WR_CLO, WR_CHI: WR_REG with ids 2/3/4 and mask 0 then mask 1; in = corresponding argument half.
- WR_LEN: WR_REG, id 5, mask 0, in = length.
- WR_START: WR_REG, id 0, mask 0, in = 1.
- POLL: RD_REG, id 1, mask 0; sample rsp[0].
  - If rsp[0]=1, go to CLR_DONE.
  - Else if the poll count has reached POLL_TIMEOUT, set error and go to FIN.
  - Otherwise go to GAP.
- GAP: NOP for POLL_GAP cycles, then POLL.
- CLR_DONE: WR_REG, id 1, mask 0, in = 0. If length=0, go to FIN; else go to READ.
- READ: RD_MEM, id 0, mask 0, addr = (c_base[31:0] >> ADDR_SHIFT) + idx. Load rsp into rd_data, set rd_valid, go to HOLD.
- HOLD: NOP. On the rd_valid & rd_ready handshake, increment idx.
  - If idx+1 = length, go to FIN.
  - Else, in the same cycle, go to READ.
- FIN: NOP, done=1, busy→0, go to IDLE.

Arithmetic and control rules:
- Address arithmetic is 32-bit modulo; wrap-around is permitted and not flagged.
- In every state not listed above, opcode = 0 and id/mask/in/addr = 0.
- start while busy is ignored and has no side effects.
- Argument registers latch only on an accepted start. External changes during a run have no effect.
- rd_valid stays high with rd_data stable until the handshake completes.

## Timing

- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-run forces these values immediately (asynchronous); nothing resumes afterwards.
- Start accepted at cycle T. Commands: WR_ALO at T+1 … WR_START at T+8, first POLL at T+9.
- Each command is asserted for exactly one cycle. rsp is sampled at the rising edge that ends that cycle.
- Poll period = POLL_GAP+1 cycles.
- Result throughput with rd_ready held at 1 is one word per 2 cycles (READ, HOLD).
- done is asserted in the cycle after the last handshake, or after the timeout decision. busy falls in that same cycle.
- A start in the FIN cycle is ignored; a start in the first IDLE cycle is accepted.

## Structure

- Shared package vadd_host_pkg holds:
  - opcode constants (NOP, WR_REG, RD_REG, WR_MEM, RD_MEM);
  - register id constants;
  - the state enum.
- All counters (gap, poll, idx) are inline. No sub-module is needed.
- The harness instantiates vadd_host_driver with its command outputs wired directly to the responder's inputs and rsp to its `out`.

## Test plan

- Basic run:
  - Stimulus: start with a_base=0x1_0000_0000, b_base=0x40, c_base=0x80, length=3.
  - Expected command trace: (1,2,0,0x0), (1,2,1,0x1), (1,3,0,0x40), …, (1,5,0,3), (1,0,0,1).
- Completion poll:
  - Stimulus: responder model asserts ap_done on the 3rd poll.
  - Expected: exactly 3 RD_REG id1 commands spaced POLL_GAP+1 cycles apart, followed by (1,1,0,0).
- Readback with backpressure:
  - Stimulus: mem[0x20..0x22]=7,8,9; rd_ready toggling 1,0,0,1.
  - Expected: rd_data sequence 7,8,9 with no loss or duplication, RD_MEM addrs 0x20,0x21,0x22, then a done pulse.
- Timeout:
  - Stimulus: POLL_TIMEOUT=5, ap_done never set.
  - Expected: 5 polls, error=1, done pulse, no CLR_DONE and no READ issued.
- Zero length and ignored start:
  - Stimulus: length=0; a second start pulse while busy.
  - Expected: CLR_DONE goes directly to FIN, rd_valid never asserts, and the extra start produces no second run.
- Reset mid-run:
  - Stimulus: assert reset during POLL.
  - Expected: opcode=0, busy=0, rd_valid=0 in the same cycle; a fresh start afterwards produces the full write sequence again.
